// File: rtl/cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : cfg_sequencer_if
// Description : Configuration-word handshake bundle between a job source
//               (master) and the cfg_sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface cfg_sequencer_if #(
    parameter int N             = 3,
    parameter int SEL_WIDTH     = $clog2(N),
    parameter int NUM_COL_WIDTH = $clog2(N),
    parameter int RUN_WIDTH     = 16
);
    logic                                 cfg_valid_i;
    logic                                 cfg_ready_o;
    logic [SEL_WIDTH+NUM_COL_WIDTH+1:0]   cfg_data_i;
    logic [RUN_WIDTH-1:0]                 run_len_i;

    modport slave (
        input  cfg_valid_i,
        input  cfg_data_i,
        input  run_len_i,
        output cfg_ready_o
    );

    modport master (
        output cfg_valid_i,
        output cfg_data_i,
        output run_len_i,
        input  cfg_ready_o
    );
endinterface
`default_nettype wire

// File: rtl/cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cfg_sequencer
// Description : Accepts one configuration word per job and walks the
//               downstream control stage through LOAD(2) / READY(2) /
//               START(1) / RUN(run_len) / FLUSH(1), with abort support.
//               All outputs are registered, decoded from the next state.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_sequencer #(
    parameter int N             = 3,
    parameter int SEL_WIDTH     = $clog2(N),
    parameter int NUM_COL_WIDTH = $clog2(N),
    parameter int RUN_WIDTH     = 16
) (
    input  wire logic                     clk_i,
    input  wire logic                     f_sel_rst,
    cfg_sequencer_if.slave                cfg_if,
    input  wire logic                     abort_i,
    output logic [SEL_WIDTH-1:0]          f_sel_o,
    output logic [NUM_COL_WIDTH-1:0]      column_num_o,
    output logic                          en_adder_1_o,
    output logic                          en_adder_2_o,
    output logic                          rst_o,
    output logic                          load_o,
    output logic                          ready_o,
    output logic                          start_op_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam logic [RUN_WIDTH-1:0] c_ONE = {{(RUN_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READY = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4,
        S_FLUSH = 3'd5
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        r_phase;      // second cycle of LOAD / READY
    logic                        w_phase_nxt;
    logic [RUN_WIDTH-1:0]        r_cnt;
    logic [RUN_WIDTH-1:0]        w_cnt_nxt;
    logic [RUN_WIDTH-1:0]        r_run_len;
    logic                        w_accept;

    logic                        r_cfg_ready;
    logic                        r_rst;
    logic                        r_load;
    logic                        r_ready;
    logic                        r_start;
    logic                        r_busy;
    logic                        r_done;
    logic [SEL_WIDTH-1:0]        r_f_sel;
    logic [NUM_COL_WIDTH-1:0]    r_col;
    logic                        r_en1;
    logic                        r_en2;

    // State, phase and run counter registers
    always_ff @(posedge clk_i or posedge f_sel_rst) begin
        if (f_sel_rst) begin
            r_state <= S_IDLE;
            r_phase <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: handshake, fixed-length phases, run countdown, abort
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // r_cfg_ready is low for the first cycle after reset release
                if (cfg_if.cfg_valid_i && r_cfg_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_LOAD;
                    w_phase_nxt = 1'b0;
                end
            end
            S_LOAD: begin
                if (abort_i) begin
                    w_state_nxt = S_FLUSH;
                end else if (r_phase) begin
                    w_state_nxt = S_READY;
                    w_phase_nxt = 1'b0;
                end else begin
                    w_phase_nxt = 1'b1;
                end
            end
            S_READY: begin
                if (abort_i) begin
                    w_state_nxt = S_FLUSH;
                end else if (r_phase) begin
                    w_state_nxt = S_START;
                    w_phase_nxt = 1'b0;
                end else begin
                    w_phase_nxt = 1'b1;
                end
            end
            S_START: begin
                if (abort_i) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_cnt_nxt   = r_run_len;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Abort and terminal count both land in a single FLUSH
                if (abort_i || (r_cnt == c_ONE)) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_IDLE;
                w_phase_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_phase_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs decoded from the next state, plus config latch
    always_ff @(posedge clk_i or posedge f_sel_rst) begin
        if (f_sel_rst) begin
            r_cfg_ready <= 1'b0;
            r_rst       <= 1'b1;
            r_load      <= 1'b0;
            r_ready     <= 1'b0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_f_sel     <= '0;
            r_col       <= '0;
            r_en1       <= 1'b0;
            r_en2       <= 1'b0;
            r_run_len   <= '0;
        end else begin
            r_cfg_ready <= (w_state_nxt == S_IDLE);
            r_rst       <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_FLUSH);
            r_load      <= (w_state_nxt == S_LOAD);
            r_ready     <= (w_state_nxt == S_READY);
            r_start     <= (w_state_nxt == S_START) || (w_state_nxt == S_RUN);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_FLUSH);
            if (w_accept) begin
                r_f_sel   <= cfg_if.cfg_data_i[SEL_WIDTH-1:0];
                r_col     <= cfg_if.cfg_data_i[SEL_WIDTH +: NUM_COL_WIDTH];
                r_en1     <= cfg_if.cfg_data_i[SEL_WIDTH+NUM_COL_WIDTH];
                r_en2     <= cfg_if.cfg_data_i[SEL_WIDTH+NUM_COL_WIDTH+1];
                // A zero run length still executes one compute cycle
                r_run_len <= (cfg_if.run_len_i == '0) ? c_ONE : cfg_if.run_len_i;
            end
        end
    end

    assign cfg_if.cfg_ready_o = r_cfg_ready;
    assign f_sel_o            = r_f_sel;
    assign column_num_o       = r_col;
    assign en_adder_1_o       = r_en1;
    assign en_adder_2_o       = r_en2;
    assign rst_o              = r_rst;
    assign load_o             = r_load;
    assign ready_o            = r_ready;
    assign start_op_o         = r_start;
    assign busy_o             = r_busy;
    assign done_o             = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_sequencer
// Description : Self-checking bench for cfg_sequencer: vector table of jobs,
//               hand-written corner sequences and random traffic checked
//               against a job-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_sequencer;

    localparam int N  = 3;
    localparam int SW = 2;
    localparam int CW = 2;
    localparam int RW = 16;
    localparam int DW = SW + CW + 2;

    logic            clk_i = 1'b0;
    logic            f_sel_rst;
    logic            abort_i;
    logic [SW-1:0]   f_sel_o;
    logic [CW-1:0]   column_num_o;
    logic            en_adder_1_o, en_adder_2_o;
    logic            rst_o, load_o, ready_o, start_op_o, busy_o, done_o;

    always #5 clk_i = ~clk_i;

    cfg_sequencer_if #(.N(N), .SEL_WIDTH(SW), .NUM_COL_WIDTH(CW), .RUN_WIDTH(RW)) cfg_if ();

    cfg_sequencer #(.N(N), .SEL_WIDTH(SW), .NUM_COL_WIDTH(CW), .RUN_WIDTH(RW)) dut (
        .clk_i        (clk_i),
        .f_sel_rst    (f_sel_rst),
        .cfg_if       (cfg_if.slave),
        .abort_i      (abort_i),
        .f_sel_o      (f_sel_o),
        .column_num_o (column_num_o),
        .en_adder_1_o (en_adder_1_o),
        .en_adder_2_o (en_adder_2_o),
        .rst_o        (rst_o),
        .load_o       (load_o),
        .ready_o      (ready_o),
        .start_op_o   (start_op_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a job is a timeline counted from acceptance.
    // Cycle 1-2 LOAD, 3-4 READY, 5 START, 6..5+len RUN, 6+len FLUSH.
    // An abort seen in a busy cycle moves FLUSH to the following cycle.
    int              m_t;      // 0 = idle, else position in job timeline
    int              m_end;    // timeline position of the FLUSH cycle
    bit              m_rdy;    // idle and able to accept
    logic [DW-1:0]   m_data;

    function automatic void model_edge();
        int len;
        if (f_sel_rst) begin
            m_t = 0; m_end = 0; m_rdy = 1'b0; m_data = '0;
        end else if (m_t == 0) begin
            if (cfg_if.cfg_valid_i && m_rdy) begin
                len    = (cfg_if.run_len_i == '0) ? 1 : int'(cfg_if.run_len_i);
                m_t    = 1;
                m_end  = 6 + len;
                m_data = cfg_if.cfg_data_i;
                m_rdy  = 1'b0;
            end else begin
                m_rdy = 1'b1;
            end
        end else if (m_t == m_end) begin
            m_t   = 0;
            m_rdy = 1'b1;
        end else begin
            if (abort_i) m_end = m_t + 1;
            m_t++;
        end
    endfunction

    // {cfg_ready, rst, load, ready, start_op, busy, done, cfg fields}
    function automatic logic [12:0] model_out();
        logic fl;
        if (m_t == 0) return {m_rdy, 1'b1, 5'b00000, m_data};
        fl = (m_t == m_end);
        return {1'b0, fl, (m_t <= 2) && !fl, (m_t >= 3) && (m_t <= 4) && !fl,
                (m_t >= 5) && !fl, 1'b1, fl, m_data};
    endfunction

    function automatic logic [12:0] dut_out();
        return {cfg_if.cfg_ready_o, rst_o, load_o, ready_o, start_op_o, busy_o, done_o,
                en_adder_2_o, en_adder_1_o, column_num_o, f_sel_o};
    endfunction

    task automatic step();
        int nstb;
        model_edge();
        @(posedge clk_i);
        #1;
        check("outputs", 32'(dut_out()), 32'(model_out()));
        nstb = int'(load_o) + int'(ready_o) + int'(start_op_o);
        check("strobe_excl", 32'(nstb <= 1), 32'd1);
        if (!f_sel_rst && !(m_t == 0 && !m_rdy))
            check("busy_vs_cfg_ready", 32'(busy_o ^ cfg_if.cfg_ready_o), 32'd1);
    endtask

    // Runs one job; abort_at is a 1-based job-cycle index (1 = first LOAD), 0 = none
    task automatic run_job(input logic [DW-1:0] data, input logic [RW-1:0] len, input int abort_at,
                           output int nload, output int nready, output int nstart,
                           output int ndone, output logic [DW-1:0] fields);
        int guard;
        int jc;
        nload = 0; nready = 0; nstart = 0; ndone = 0; fields = '0;
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_data_i  = data;
        cfg_if.run_len_i   = len;
        abort_i            = 1'b0;
        guard = 0;
        while (!busy_o && guard < 10) begin step(); guard++; end
        cfg_if.cfg_valid_i = 1'b0;
        if (!busy_o) check("job_accept_timeout", 32'd0, 32'd1);
        fields = {en_adder_2_o, en_adder_1_o, column_num_o, f_sel_o};
        jc = 1;
        guard = 0;
        while (busy_o && guard < int'(len) + 40) begin
            nload  += int'(load_o);
            nready += int'(ready_o);
            nstart += int'(start_op_o);
            ndone  += int'(done_o);
            abort_i = (abort_at != 0) && (jc == abort_at);
            step();
            jc++;
            guard++;
        end
        abort_i = 1'b0;
        if (busy_o) check("job_end_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic [RW-1:0] len;
        int            abort_at;
        int            exp_load;
        int            exp_ready;
        int            exp_start;
        int            exp_done;
    } job_vec_t;

    job_vec_t vecs[$];

    initial begin
        int nl, nr, ns, nd;
        logic [DW-1:0] fl;
        logic [DW-1:0] word_a;
        int guard;

        // {en2, en1, column, f_sel}
        vecs.push_back('{6'b10_10_01, 16'd5,     0, 2, 2, 6,     1});
        vecs.push_back('{6'b00_00_00, 16'd0,     0, 2, 2, 2,     1});
        vecs.push_back('{6'b01_01_10, 16'd1,     0, 2, 2, 2,     1});
        vecs.push_back('{6'b11_11_11, 16'd100,   8, 2, 2, 4,     1});
        vecs.push_back('{6'b10_01_00, 16'd3,     8, 2, 2, 4,     1});
        vecs.push_back('{6'b01_10_10, 16'd7,     5, 2, 2, 1,     1});
        vecs.push_back('{6'b00_11_01, 16'd9,     1, 1, 0, 0,     1});
        vecs.push_back('{6'b11_00_10, 16'd9,     4, 2, 2, 0,     1});
        vecs.push_back('{6'b00_11_01, 16'hFFFF,  0, 2, 2, 65536, 1});

        f_sel_rst          = 1'b1;
        abort_i            = 1'b0;
        cfg_if.cfg_valid_i = 1'b0;
        cfg_if.cfg_data_i  = '0;
        cfg_if.run_len_i   = '0;
        m_t = 0; m_end = 0; m_rdy = 1'b0; m_data = '0;

        step();
        step();
        f_sel_rst = 1'b0;
        step();
        check("cfg_ready_after_reset", 32'(cfg_if.cfg_ready_o), 32'd1);

        // Vector table
        foreach (vecs[i]) begin
            run_job(vecs[i].data, vecs[i].len, vecs[i].abort_at, nl, nr, ns, nd, fl);
            check($sformatf("vec%0d_load_cycles", i),  32'(nl), 32'(vecs[i].exp_load));
            check($sformatf("vec%0d_ready_cycles", i), 32'(nr), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d_start_cycles", i), 32'(ns), 32'(vecs[i].exp_start));
            check($sformatf("vec%0d_done_pulses", i),  32'(nd), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d_fields", i),       32'(fl), 32'(vecs[i].data));
            step();
            step();
        end

        // Valid held through a whole job: second word waits for IDLE
        word_a = 6'b10_01_11;
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_data_i  = word_a;
        cfg_if.run_len_i   = 16'd2;
        guard = 0;
        while (!busy_o && guard < 10) begin step(); guard++; end
        cfg_if.cfg_data_i = 6'b01_10_00;
        cfg_if.run_len_i  = 16'd3;
        guard = 0;
        while (!done_o && guard < 20) begin
            check("held_fields_job1", 32'({en_adder_2_o, en_adder_1_o, column_num_o, f_sel_o}), 32'(word_a));
            check("held_no_accept", 32'(cfg_if.cfg_ready_o), 32'd0);
            step();
            guard++;
        end
        check("held_done_seen", 32'(done_o), 32'd1);
        step();
        check("held_idle_gap", 32'(busy_o), 32'd0);
        step();
        check("held_second_accept", 32'(load_o), 32'd1);
        check("held_fields_job2", 32'({en_adder_2_o, en_adder_1_o, column_num_o, f_sel_o}), 32'(6'b01_10_00));
        cfg_if.cfg_valid_i = 1'b0;
        guard = 0;
        while (busy_o && guard < 30) begin step(); guard++; end
        step();

        // Asynchronous reset in READY: immediate reset, no done pulse
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_data_i  = 6'b11_10_01;
        cfg_if.run_len_i   = 16'd10;
        guard = 0;
        while (!ready_o && guard < 10) begin step(); guard++; end
        cfg_if.cfg_valid_i = 1'b0;
        check("reached_ready", 32'(ready_o), 32'd1);
        #2;
        f_sel_rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'(dut_out()), 32'(13'b0_1_00000_000000));
        step();
        check("reset_no_done", 32'(done_o), 32'd0);
        f_sel_rst = 1'b0;
        step();
        check("cfg_ready_after_midjob_reset", 32'(cfg_if.cfg_ready_o), 32'd1);

        // Random back-to-back traffic against the model
        for (int c = 0; c < 600; c++) begin
            cfg_if.cfg_valid_i = ($urandom_range(0, 3) != 0);
            cfg_if.cfg_data_i  = DW'($urandom);
            cfg_if.run_len_i   = RW'($urandom_range(0, 10));
            abort_i            = ($urandom_range(0, 15) == 0);
            f_sel_rst          = ($urandom_range(0, 199) == 0);
            step();
        end
        f_sel_rst          = 1'b0;
        abort_i            = 1'b0;
        cfg_if.cfg_valid_i = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
